maple_txn_seq: RTL and testbench
================================

# maple_txn_seq

Hardware transaction sequencer for one Maple bus exchange. It sits beside the output controller, input controller, FIFOs and clock divider. It replaces manual register pokes with a single command: select port, send the frame already in the write FIFO with START/END, arm the receiver, then wait for the reply under a tick-based timeout. Completion and a 2-bit status are reported to the register file / host logic.

## Interface
Parameters:
- SETTLE_TICKS, 4: ticks to wait after changing port_select before transmitting
- TX_GUARD_TICKS, 16: ticks allowed for maple_oe to assert after the transmit trigger
- TO_W, 16: width of the reply timeout counter

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle strobe from the clock divider
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_port  in  2  target port
- cmd_rx  in  1  1 = expect a reply frame
- cmd_timeout  in  TO_W  reply timeout in ticks
- abort  in  1  level; cancel the current command
- port_select  out  2  to the physical port mux
- out_trigger_start, out_trigger_end  out  1  one-cycle pulses to the output controller
- maple_oe  in  1  bus is transmitting
- in_trigger_start, in_trigger_end  out  1  one-cycle pulses to the input controller
- in_start_detected, in_end_detected  in  1  input controller status
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on completion
- status  out  2  00 ok, 01 reply timeout, 10 tx fault, 11 aborted; held until next accept

## Operation
- States: IDLE, SETTLE, TX_ARM, TX_RUN, RX_WAIT, RX_DATA, FINISH.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_port, cmd_rx and cmd_timeout. port_select takes the new value the next cycle, and the FSM goes to SETTLE. If cmd_port equals the current port_select, SETTLE is skipped and the FSM goes directly to TX_ARM.
- SETTLE: count SETTLE_TICKS ticks, then go to TX_ARM.
- TX_ARM: on entry, pulse out_trigger_start and out_trigger_end in the same cycle (START, FIFO data, END).
  - Stay until maple_oe=1, then go to TX_RUN.
  - If TX_GUARD_TICKS ticks elapse first: status=10, go to FINISH.
- TX_RUN: wait for maple_oe=0. Then:
  - if cmd_rx, pulse in_trigger_start and load the timer with cmd_timeout, go to RX_WAIT;
  - otherwise status=00, go to FINISH.
- Reply timer: decrements on tick in RX_WAIT and RX_DATA and is shared by both, so it bounds the whole reply. Timeout fires when the timer is 0 and a tick occurs. cmd_timeout=0 therefore times out on the first tick.
- RX_WAIT: in_start_detected → RX_DATA. Timeout → pulse in_trigger_end, status=01, go to FINISH.
- RX_DATA: in_end_detected → status=00, go to FINISH. Timeout → pulse in_trigger_end, status=01, go to FINISH.
- FINISH: pulse done for one cycle, go to IDLE.
- Abort handling:
  - SETTLE: status=11, go to FINISH immediately.
  - RX_WAIT / RX_DATA: pulse in_trigger_end, status=11, go to FINISH.
  - TX_ARM / TX_RUN: an in-progress frame is never cut. Abort is latched, and status=11 is reported once maple_oe falls (or the guard expires); the receiver is not armed.
  - IDLE: abort is ignored.
- Simultaneous events:
  - in_end_detected together with a timeout → ok wins.
  - abort together with in_end_detected → ok wins.
- An empty write FIFO is not checked: START/END are still sent.

## Timing
- Reset values: port_select=0, status=00, all trigger outputs=0, done=0, busy=0, cmd_ready=1, timer=0, state=IDLE.
- rst asserted in any state returns the FSM to IDLE on the next edge. No trigger pulses are emitted during or after reset.
- Accept-to-out_trigger pulse latency:
  - 2 cycles when the port is unchanged (accept, then TX_ARM entry);
  - otherwise SETTLE_TICKS ticks plus 2 cycles.
- in_trigger_start is asserted in the cycle after maple_oe is sampled low in TX_RUN.
- status is updated in the cycle the FSM enters FINISH, so it is stable when done=1.
- A new command can be accepted in the cycle after done.

## Structure
- Put the state enum and the status codes (ST_OK, ST_TIMEOUT, ST_TXFAULT, ST_ABORT) in the shared package maple_pkg, so the register file can decode status.
- Sub-module maple_tick_timer: a loadable down-counter with a tick enable and an expired flag, TO_W-wide. It is used for the reply timeout; separate small instances serve the settle and tx-guard counts.

## Test plan
- Same port, cmd_rx=0, maple_oe high for 50 cycles → triggers 2 cycles after accept, done with status 00, no in_trigger_start.
- Port 0→2, SETTLE_TICKS=4 → port_select=2 one cycle after accept, out_trigger pulses after the 4th tick.
- cmd_rx=1, cmd_timeout=10, in_start_detected after 3 ticks and in_end_detected after 7 → status 00.
- cmd_rx=1, cmd_timeout=5, no start detected → in_trigger_end pulse after the 6th tick, status 01.
- maple_oe never rises → status 10 after 16 ticks.
- abort during TX_RUN → done only after maple_oe falls, status 11, no in_trigger_start.
- rst mid-RX_DATA → busy=0 and outputs at reset values on the next cycle.

Source files
------------

// File: rtl/maple_pkg.sv
// Shared definitions for the Maple transaction sequencer: FSM state codes
// and the 2-bit completion status codes decoded by the register file.
package maple_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned STATUS_W = 2;

   typedef logic [STATE_W-1:0]  state_t;
   typedef logic [STATUS_W-1:0] status_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_SETTLE  = 3'd1;
   localparam state_t S_TX_ARM  = 3'd2;
   localparam state_t S_TX_RUN  = 3'd3;
   localparam state_t S_RX_WAIT = 3'd4;
   localparam state_t S_RX_DATA = 3'd5;
   localparam state_t S_FINISH  = 3'd6;

   localparam status_t ST_OK      = 2'b00;
   localparam status_t ST_TIMEOUT = 2'b01;
   localparam status_t ST_TXFAULT = 2'b10;
   localparam status_t ST_ABORT   = 2'b11;

endpackage

// File: rtl/maple_tick_timer.sv
// Loadable tick-enabled down-counter.
// Ports: clk/rst (sync, active-high), load_i/load_val_i load the count,
// en_i gates counting, tick_i is the divider strobe, expired_c_o is high
// when a tick arrives while enabled and the count is already zero.
module maple_tick_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         tick_i,
   output logic         expired_c_o
);

   logic [W-1:0] count_q, count_d;
   logic         zero;

   assign zero        = (count_q == '0);
   // A load of N therefore expires on the (N+1)-th enabled tick.
   assign expired_c_o = en_i && tick_i && zero;

   // Load wins over counting; the count saturates at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && tick_i && !zero) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/maple_txn_seq.sv
// Maple bus transaction sequencer: selects a port, fires START/END to the
// output controller, optionally arms the receiver and waits for the reply
// under a tick-based timeout, then reports done plus a 2-bit status.
// Ports: clk/rst (sync, active-high); tick divider strobe; cmd_* command
// handshake; abort level cancel; port_select to the port mux;
// out_trigger_* / in_trigger_* one-cycle pulses; maple_oe and
// in_*_detected status from the controllers; busy, done, status.
module maple_txn_seq
   import maple_pkg::*;
#(
   parameter int unsigned SETTLE_TICKS   = 4,
   parameter int unsigned TX_GUARD_TICKS = 16,
   parameter int unsigned TO_W           = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_port,
   input  logic            cmd_rx,
   input  logic [TO_W-1:0] cmd_timeout,
   input  logic            abort,
   output logic [1:0]      port_select,
   output logic            out_trigger_start,
   output logic            out_trigger_end,
   input  logic            maple_oe,
   output logic            in_trigger_start,
   output logic            in_trigger_end,
   input  logic            in_start_detected,
   input  logic            in_end_detected,
   output logic            busy,
   output logic            done,
   output logic [1:0]      status
);

   localparam int unsigned SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
   localparam int unsigned GRD_W = (TX_GUARD_TICKS > 1) ? $clog2(TX_GUARD_TICKS) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_TICKS - 1);
   localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(TX_GUARD_TICKS - 1);

   state_t          state_q, state_d;
   logic [1:0]      port_q, port_d;
   logic            rx_q, rx_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            abort_q, abort_d;
   logic            fired_q, fired_d;
   status_t         status_q, status_d;
   logic            done_q, done_d;
   logic            otrig_q, otrig_d;
   logic            itrs_q, itrs_d;
   logic            itre_q, itre_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;

   logic set_load, grd_load, rep_load;
   logic set_en, grd_en, rep_en;
   logic set_exp_c, grd_exp_c, rep_exp_c;
   logic abort_any;

   // Guard counts only once the START/END pulse has gone out.
   assign set_en    = (state_q == S_SETTLE);
   assign grd_en    = (state_q == S_TX_ARM) && fired_q;
   assign rep_en    = (state_q == S_RX_WAIT) || (state_q == S_RX_DATA);
   assign abort_any = abort || abort_q;

   maple_tick_timer #(.W(SET_W)) u_settle (
      .clk(clk), .rst(rst), .load_i(set_load), .load_val_i(SET_LOAD),
      .en_i(set_en), .tick_i(tick), .expired_c_o(set_exp_c)
   );

   maple_tick_timer #(.W(GRD_W)) u_guard (
      .clk(clk), .rst(rst), .load_i(grd_load), .load_val_i(GRD_LOAD),
      .en_i(grd_en), .tick_i(tick), .expired_c_o(grd_exp_c)
   );

   // Shared by RX_WAIT and RX_DATA so it bounds the whole reply.
   maple_tick_timer #(.W(TO_W)) u_reply (
      .clk(clk), .rst(rst), .load_i(rep_load), .load_val_i(to_q),
      .en_i(rep_en), .tick_i(tick), .expired_c_o(rep_exp_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      rx_d     = rx_q;
      to_d     = to_q;
      abort_d  = abort_q;
      fired_d  = fired_q;
      status_d = status_q;
      otrig_d  = 1'b0;
      itrs_d   = 1'b0;
      itre_d   = 1'b0;
      set_load = 1'b0;
      grd_load = 1'b0;
      rep_load = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               port_d   = cmd_port;
               rx_d     = cmd_rx;
               to_d     = cmd_timeout;
               abort_d  = 1'b0;
               fired_d  = 1'b0;
               status_d = ST_OK;
               set_load = 1'b1;
               state_d  = (cmd_port == port_q) ? S_TX_ARM : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else if (set_exp_c) begin
               state_d = S_TX_ARM;
            end
         end
         S_TX_ARM: begin
            // A frame is never cut: abort is only remembered here.
            if (abort) begin
               abort_d = 1'b1;
            end
            if (!fired_q) begin
               otrig_d  = 1'b1;
               fired_d  = 1'b1;
               grd_load = 1'b1;
            end else if (maple_oe) begin
               state_d = S_TX_RUN;
            end else if (grd_exp_c) begin
               status_d = abort_any ? ST_ABORT : ST_TXFAULT;
               state_d  = S_FINISH;
            end
         end
         S_TX_RUN: begin
            if (abort) begin
               abort_d = 1'b1;
            end
            if (!maple_oe) begin
               if (abort_any) begin
                  status_d = ST_ABORT;
                  state_d  = S_FINISH;
               end else if (rx_q) begin
                  itrs_d   = 1'b1;
                  rep_load = 1'b1;
                  state_d  = S_RX_WAIT;
               end else begin
                  status_d = ST_OK;
                  state_d  = S_FINISH;
               end
            end
         end
         S_RX_WAIT: begin
            if (abort) begin
               itre_d   = 1'b1;
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else if (in_start_detected) begin
               state_d = S_RX_DATA;
            end else if (rep_exp_c) begin
               itre_d   = 1'b1;
               status_d = ST_TIMEOUT;
               state_d  = S_FINISH;
            end
         end
         S_RX_DATA: begin
            // A completed reply beats both abort and timeout.
            if (in_end_detected) begin
               status_d = ST_OK;
               state_d  = S_FINISH;
            end else if (abort) begin
               itre_d   = 1'b1;
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else if (rep_exp_c) begin
               itre_d   = 1'b1;
               status_d = ST_TIMEOUT;
               state_d  = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d  = (state_d == S_FINISH);
      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         port_q   <= 2'd0;
         rx_q     <= 1'b0;
         to_q     <= '0;
         abort_q  <= 1'b0;
         fired_q  <= 1'b0;
         status_q <= ST_OK;
         done_q   <= 1'b0;
         otrig_q  <= 1'b0;
         itrs_q   <= 1'b0;
         itre_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         rx_q     <= rx_d;
         to_q     <= to_d;
         abort_q  <= abort_d;
         fired_q  <= fired_d;
         status_q <= status_d;
         done_q   <= done_d;
         otrig_q  <= otrig_d;
         itrs_q   <= itrs_d;
         itre_q   <= itre_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

   assign cmd_ready         = ready_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign status            = status_q;
   assign port_select       = port_q;
   assign out_trigger_start = otrig_q;
   assign out_trigger_end   = otrig_q;
   assign in_trigger_start  = itrs_q;
   assign in_trigger_end    = itre_q;

endmodule

// File: tb/tb_maple_txn_seq.sv
// Bench for maple_txn_seq: plays the bus agent, counts its own ticks and
// predicts every pulse/status cycle from the transaction rules.
module tb_maple_txn_seq;
   import maple_pkg::*;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned GUARD  = 16;
   localparam int unsigned TO_W   = 16;
   localparam int K_NORM = 0, K_TXF = 1, K_ABTX = 2, K_ABSET = 3;

   logic            clk, rst, tick, cmd_valid, cmd_ready, cmd_rx, abort;
   logic [1:0]      cmd_port, port_select, status;
   logic [TO_W-1:0] cmd_timeout;
   logic            out_trigger_start, out_trigger_end, maple_oe;
   logic            in_trigger_start, in_trigger_end;
   logic            in_start_detected, in_end_detected, busy, done;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] cur_port;

   typedef struct {
      logic [1:0] port;
      bit         rx;
      int         to;
      int         kind;
      int         oe_len;
      int         start_at;
      int         end_at;
      bit         end_tick;
      bit         end_abort;
      int         abort_at;
      int         rst_at;
   } txn_t;

   maple_txn_seq #(.SETTLE_TICKS(SETTLE), .TX_GUARD_TICKS(GUARD), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_port(cmd_port), .cmd_rx(cmd_rx), .cmd_timeout(cmd_timeout), .abort(abort),
      .port_select(port_select), .out_trigger_start(out_trigger_start),
      .out_trigger_end(out_trigger_end), .maple_oe(maple_oe),
      .in_trigger_start(in_trigger_start), .in_trigger_end(in_trigger_end),
      .in_start_detected(in_start_detected), .in_end_detected(in_end_detected),
      .busy(busy), .done(done), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input logic [1:0] exp_st);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ready", 32'(cmd_ready), 1);
      chk("idle_done", 32'(done), 0);
      chk("idle_triggers", 32'({out_trigger_start, out_trigger_end, in_trigger_start, in_trigger_end}), 0);
      chk("idle_status", 32'(status), 32'(exp_st));
   endtask

   task automatic finish_chk(input logic [1:0] exp_st, input logic exp_ite);
      chk("done", 32'(done), 1);
      chk("status", 32'(status), 32'(exp_st));
      chk("in_trigger_end", 32'(in_trigger_end), 32'(exp_ite));
      chk("busy_in_finish", 32'(busy), 1);
      chk("finish_quiet", 32'({in_trigger_start, out_trigger_start}), 0);
      tick = rbit();
      step();
      tick = 1'b0;
      idle_chk(exp_st);
   endtask

   function automatic txn_t mk(input int port, input int rx, input int to, input int kind,
                               input int oe_len, input int s, input int e, input int et,
                               input int ea, input int ab, input int rs);
      txn_t t;
      t.port = 2'(port);  t.rx = 1'(rx);  t.to = to;  t.kind = kind;  t.oe_len = oe_len;
      t.start_at = s;  t.end_at = e;  t.end_tick = 1'(et);  t.end_abort = 1'(ea);
      t.abort_at = ab;  t.rst_at = rs;
      return t;
   endfunction

   task automatic run_txn(input txn_t t);
      bit settle;
      bit started;
      bit finished;
      int kind;
      int cnt;
      int d;
      int ab;
      int ev;
      kind   = t.kind;
      settle = (t.port != cur_port);
      if (kind == K_ABSET && !settle) kind = K_NORM;

      // Accept; abort in the accept cycle is sampled in IDLE and must be ignored.
      chk("ready_before_accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;  cmd_port = t.port;  cmd_rx = t.rx;  cmd_timeout = TO_W'(t.to);
      abort = rbit();  tick = rbit();
      step();
      cmd_valid = 1'b0;  abort = 1'b0;
      cmd_port = 2'($urandom);  cmd_rx = rbit();  cmd_timeout = TO_W'($urandom);
      cur_port = t.port;
      chk("port_select", 32'(port_select), 32'(t.port));
      chk("busy_after_accept", 32'(busy), 1);
      chk("ready_after_accept", 32'(cmd_ready), 0);

      if (settle) begin
         cnt = 0;
         ab  = (kind == K_ABSET) ? int'($urandom_range(0, SETTLE - 1)) : -1;
         while (cnt < int'(SETTLE)) begin
            if (cnt == ab) begin
               abort = 1'b1;  tick = 1'b0;
               step();
               abort = 1'b0;
               finish_chk(ST_ABORT, 1'b0);
               return;
            end
            tick = rbit();
            step();
            if (tick) cnt++;
            chk("settle_no_trigger", 32'({out_trigger_start, out_trigger_end}), 0);
         end
      end else begin
         chk("trigger_not_before_entry", 32'({out_trigger_start, out_trigger_end}), 0);
      end
      tick = rbit();
      step();
      chk("out_trigger_start", 32'(out_trigger_start), 1);
      chk("out_trigger_end", 32'(out_trigger_end), 1);

      if (kind == K_TXF) begin
         cnt = 0;
         while (cnt < int'(GUARD)) begin
            maple_oe = 1'b0;  tick = rbit();
            step();
            if (tick) cnt++;
            if (cnt < int'(GUARD)) chk("guard_quiet", 32'({done, out_trigger_start}), 0);
         end
         tick = 1'b0;
         finish_chk(ST_TXFAULT, 1'b0);
         return;
      end

      d  = int'($urandom_range(0, 3));
      ab = (kind == K_ABTX) ? int'($urandom_range(0, d + t.oe_len - 1)) : -1;
      for (int i = 0; i < d + t.oe_len; i++) begin
         maple_oe = (i >= d);  abort = (i == ab);  tick = rbit();
         step();
         chk("tx_quiet", 32'({done, in_trigger_start, out_trigger_start}), 0);
      end
      maple_oe = 1'b0;  abort = 1'b0;  tick = rbit();
      step();
      if (kind == K_ABTX || !t.rx) begin
         chk("no_in_trigger_start", 32'(in_trigger_start), 0);
         finish_chk((kind == K_ABTX) ? ST_ABORT : ST_OK, 1'b0);
         return;
      end
      chk("in_trigger_start", 32'(in_trigger_start), 1);
      chk("no_done_at_rx_arm", 32'(done), 0);

      cnt = 0;  started = 0;  finished = 0;
      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
         ev = 0;  tick = rbit();
         if (!started && t.start_at >= 0 && cnt == t.start_at) begin
            in_start_detected = 1'b1;  tick = 1'b0;  started = 1;
         end else if (started && t.end_at >= 0 && cnt == t.end_at) begin
            in_end_detected = 1'b1;  tick = t.end_tick;  abort = t.end_abort;  ev = 1;
         end else if (t.abort_at >= 0 && cnt == t.abort_at) begin
            abort = 1'b1;  tick = 1'b0;  ev = 2;
         end else if (started && t.rst_at >= 0 && cnt == t.rst_at) begin
            rst = 1'b1;  ev = 3;
         end else if (tick && cnt == t.to) begin
            ev = 4;
         end
         step();
         in_start_detected = 1'b0;  in_end_detected = 1'b0;  abort = 1'b0;  rst = 1'b0;
         case (ev)
            1: begin finish_chk(ST_OK, 1'b0);      finished = 1; end
            2: begin finish_chk(ST_ABORT, 1'b1);   finished = 1; end
            4: begin finish_chk(ST_TIMEOUT, 1'b1); finished = 1; end
            3: begin
               cur_port = 2'd0;
               idle_chk(ST_OK);
               chk("port_after_rst", 32'(port_select), 0);
               tick = 1'b0;
               step();
               idle_chk(ST_OK);
               finished = 1;
            end
            default: begin
               chk("rx_quiet", 32'({done, in_trigger_end, in_trigger_start}), 0);
               if (tick) cnt++;
            end
         endcase
      end
      if (!finished) begin
         n_cmp++;  n_err++;
         $error("FAIL rx_bound: observed no completion, expected completion within 2000 cycles");
      end
      tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1;  tick = 1'b1;  cmd_valid = 1'b1;  cmd_port = 2'd2;  cmd_rx = 1'b1;
      cmd_timeout = '0;  abort = 1'b0;  maple_oe = 1'b0;
      in_start_detected = 1'b0;  in_end_detected = 1'b0;  cur_port = 2'd0;
      repeat (3) step();
      idle_chk(ST_OK);
      chk("reset_port", 32'(port_select), 0);
      cmd_valid = 1'b0;  tick = 1'b0;  rst = 1'b0;
      step();
      idle_chk(ST_OK);

      // Directed cases.
      run_txn(mk(0, 0, 0,  K_NORM,  50, -1, -1, 0, 0, -1, -1));
      run_txn(mk(2, 0, 0,  K_NORM,  3,  -1, -1, 0, 0, -1, -1));
      run_txn(mk(2, 1, 10, K_NORM,  4,  3,  7,  0, 0, -1, -1));
      run_txn(mk(2, 1, 5,  K_NORM,  2,  -1, -1, 0, 0, -1, -1));
      run_txn(mk(1, 0, 0,  K_TXF,   1,  -1, -1, 0, 0, -1, -1));
      abort = 1'b1;
      repeat (3) step();
      abort = 1'b0;
      idle_chk(ST_TXFAULT);
      run_txn(mk(1, 1, 8,  K_ABTX,  10, -1, -1, 0, 0, -1, -1));
      run_txn(mk(3, 0, 0,  K_ABSET, 1,  -1, -1, 0, 0, -1, -1));
      run_txn(mk(3, 1, 0,  K_NORM,  1,  -1, -1, 0, 0, -1, -1));
      run_txn(mk(3, 1, 6,  K_NORM,  1,  2,  6,  1, 0, -1, -1));
      run_txn(mk(3, 1, 6,  K_NORM,  1,  1,  4,  0, 1, -1, -1));
      run_txn(mk(3, 1, 9,  K_NORM,  1,  2,  -1, 0, 0, 5,  -1));
      run_txn(mk(3, 1, 9,  K_NORM,  1,  2,  -1, 0, 0, -1, 4));
      run_txn(mk(0, 1, 4,  K_NORM,  1,  2,  -1, 0, 0, -1, -1));

      // Randomized transactions.
      for (int k = 0; k < 40; k++) begin
         int p, rx, to, sel, kind, sub, s, e, et, ea, ab;
         p   = int'($urandom_range(0, 3));
         rx  = int'($urandom_range(0, 1));
         to  = int'($urandom_range(0, 12));
         sel = int'($urandom_range(0, 9));
         kind = (sel < 6 || sel == 9) ? K_NORM : (sel == 6) ? K_TXF : (sel == 7) ? K_ABTX : K_ABSET;
         s = -1;  e = -1;  et = 0;  ea = 0;  ab = -1;
         sub = int'($urandom_range(0, 4));
         case (sub)
            0: begin s = int'($urandom_range(0, to)); e = int'($urandom_range(s, to));
                     ea = int'($urandom_range(0, 1)); end
            2: s = int'($urandom_range(0, to));
            3: begin s = int'($urandom_range(0, to)); ab = int'($urandom_range(s, to)); end
            4: begin s = int'($urandom_range(0, to)); e = to; et = 1; end
            default: ;
         endcase
         run_txn(mk(p, rx, to, kind, int'($urandom_range(1, 8)), s, e, et, ea, ab, -1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
